// File: rtl/axis_packet_checker.sv
// ----------------------------------------------------------------------------
// axis_packet_checker: AXI4-Stream sink that checks generator test frames.
// Optional LFSR backpressure on s_axis_tready: AXIS_CHECKER_BACKPRESSURE_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axis_packet_checker #(
  parameter int          AXIS_DATA_WIDTH  = 256,
  parameter int          AXIS_TUSER_WIDTH = 128,
  parameter logic [47:0] DST_MAC_ADDR     = 48'h1111_1111_1111,
  parameter logic [47:0] SRC_MAC_ADDR     = 48'h2222_2222_2222,
  parameter bit          VLAN             = 1'b1,
  parameter logic [15:0] TYPE             = 16'h0800,
  parameter logic [2:0]  PRI              = 3'b111,
  parameter int          PACKET_LENGTH    = 1500,
  parameter logic [7:0]  EXP_TUSER_SRC    = 8'h01
) (
  input  logic                          axis_aclk,
  input  logic                          axis_reset,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic                          clear,
  output logic [31:0]                   pkt_count,
  output logic [31:0]                   err_count,
  output logic [15:0]                   last_len,
  output logic                          data_err,
  output logic                          len_err,
  output logic                          src_err
);

  localparam int          KW      = AXIS_DATA_WIDTH / 8;
  localparam int          CW      = $clog2(KW + 1);
  localparam logic [15:0] EXP_LEN = 16'(PACKET_LENGTH);
  localparam int          E_DATA  = 0;
  localparam int          E_LEN   = 1;
  localparam int          E_SRC   = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_FRAME = 2'd1,
    DROP     = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   offset_q, offset_d;
  logic [2:0]    err_q, err_d;
  logic          tready_q;
  logic [31:0]   pkt_q, errc_q;
  logic [15:0]   len_q;
  logic [2:0]    flags_q;

  logic          accept, beat_mis, src_mis, keep_bad, sat, all_ones, contig;
  logic [CW-1:0] keep_cnt;
  logic [KW-1:0] low_bit;
  logic [16:0]   sum;
  logic [15:0]   new_off;
  logic          fin;
  logic [2:0]    fin_err, beat_err;
  logic          unused_tuser;

  function automatic logic [7:0] exp_byte(input logic [16:0] n);
    logic [7:0] b;
    b = n[7:0];
    if (n < 17'd6) begin
      b = DST_MAC_ADDR[8*(5-int'(n)) +: 8];
    end else if (n < 17'd12) begin
      b = SRC_MAC_ADDR[8*(11-int'(n)) +: 8];
    end else if (VLAN) begin
      if (n == 17'd12)      b = 8'h81;
      else if (n == 17'd13) b = 8'h00;
      else if (n == 17'd14) b = {PRI, 5'd0};
      else if (n == 17'd15) b = 8'h00;
    end else begin
      if (n == 17'd12)      b = TYPE[15:8];
      else if (n == 17'd13) b = TYPE[7:0];
    end
    return b;
  endfunction

  assign accept       = s_axis_tvalid && tready_q;
  assign src_mis      = (s_axis_tuser[23:16] != EXP_TUSER_SRC);
  assign unused_tuser = ^s_axis_tuser;
  assign all_ones     = &s_axis_tkeep;
  // Adding the lowest set bit clears a contiguous run completely.
  assign low_bit      = s_axis_tkeep & (~s_axis_tkeep + {{(KW-1){1'b0}}, 1'b1});
  assign contig       = (((s_axis_tkeep + low_bit) & s_axis_tkeep) == '0);
  assign keep_bad     = s_axis_tlast ? !contig : !all_ones;
  assign sum          = {1'b0, offset_q} + 17'(keep_cnt);
  assign sat          = (sum >= 17'd65535);
  assign new_off      = sat ? 16'hFFFF : sum[15:0];

  always_comb begin
    keep_cnt = '0;
    beat_mis = 1'b0;
    for (int j = 0; j < KW; j++) begin
      keep_cnt = keep_cnt + CW'(s_axis_tkeep[j]);
      if (s_axis_tkeep[j] &&
          (s_axis_tdata[j*8 +: 8] != exp_byte({1'b0, offset_q} + 17'(j))))
        beat_mis = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    err_d    = err_q;
    fin      = 1'b0;
    fin_err  = '0;
    beat_err = '0;
    if (accept) begin
      unique case (state_q)
        IDLE, IN_FRAME: begin
          beat_err         = (state_q == IDLE) ? 3'b000 : err_q;
          beat_err[E_DATA] = beat_err[E_DATA] | beat_mis;
          beat_err[E_LEN]  = beat_err[E_LEN] | keep_bad | sat;
          if (state_q == IDLE) beat_err[E_SRC] = src_mis;
        end
        default: beat_err = err_q | {1'b0, sat, 1'b0};
      endcase
      if (s_axis_tlast) begin
        fin            = 1'b1;
        fin_err        = beat_err;
        fin_err[E_LEN] = beat_err[E_LEN] | (new_off != EXP_LEN);
        offset_d       = '0;
        err_d          = '0;
        state_d        = IDLE;
      end else begin
        err_d    = beat_err;
        offset_d = new_off;
        state_d  = (state_q == DROP || keep_bad || sat) ? DROP : IN_FRAME;
      end
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q  <= IDLE;
      offset_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      err_q    <= err_d;
    end
  end

  // A finalize coinciding with clear is dropped: clear has priority.
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      pkt_q   <= '0;
      errc_q  <= '0;
      len_q   <= '0;
      flags_q <= '0;
    end else if (clear) begin
      pkt_q   <= '0;
      errc_q  <= '0;
      len_q   <= '0;
      flags_q <= '0;
    end else if (fin) begin
      pkt_q <= pkt_q + 32'd1;
      len_q <= new_off;
      if (|fin_err) begin
        errc_q  <= errc_q + 32'd1;
        flags_q <= flags_q | fin_err;
      end
    end
  end

`ifdef AXIS_CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      lfsr_q   <= 16'hACE1;
      tready_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      tready_q <= lfsr_d[0];
    end
  end
`else
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) tready_q <= 1'b0;
    else            tready_q <= 1'b1;
  end
`endif

  assign s_axis_tready = tready_q;
  assign pkt_count     = pkt_q;
  assign err_count     = errc_q;
  assign last_len      = len_q;
  assign data_err      = flags_q[E_DATA];
  assign len_err       = flags_q[E_LEN];
  assign src_err       = flags_q[E_SRC];

endmodule

`default_nettype wire

// File: tb/tb_axis_packet_checker.sv
// ----------------------------------------------------------------------------
// tb_axis_packet_checker: directed bench for axis_packet_checker (64-bit data).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_axis_packet_checker;

  logic         clk;
  logic         rst;
  logic [63:0]  tdata;
  logic [7:0]   tkeep;
  logic [127:0] tuser;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic         clear;
  logic [31:0]  pkt_count;
  logic [31:0]  err_count;
  logic [15:0]  last_len;
  logic         data_err;
  logic         len_err;
  logic         src_err;

  int checks   = 0;
  int failures = 0;

  axis_packet_checker #(
    .AXIS_DATA_WIDTH(64)
  ) dut (
    .axis_aclk    (clk),
    .axis_reset   (rst),
    .s_axis_tdata (tdata),
    .s_axis_tkeep (tkeep),
    .s_axis_tuser (tuser),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .s_axis_tlast (tlast),
    .clear        (clear),
    .pkt_count    (pkt_count),
    .err_count    (err_count),
    .last_len     (last_len),
    .data_err     (data_err),
    .len_err      (len_err),
    .src_err      (src_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference frame pattern: 6x11, 6x22, 81 00 E0 00, then offset[7:0].
  function automatic logic [7:0] gen_byte(input int n);
    logic [31:0] nn;
    nn = n;
    if (n < 6)       return 8'h11;
    else if (n < 12) return 8'h22;
    else if (n == 12) return 8'h81;
    else if (n == 13) return 8'h00;
    else if (n == 14) return 8'hE0;
    else if (n == 15) return 8'h00;
    return nn[7:0];
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic [7:0] src, input logic clr);
    int guard;
    guard  = 0;
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    tuser  = {104'd0, src, 16'd0};
    tvalid = 1'b1;
    clear  = clr;
    while (tready !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) check("tready_wait", 32'(tready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    clear  = 1'b0;
  endtask

  task automatic send_frame(input int len, input int corrupt_at, input logic [7:0] src,
                            input bit clr_last, input int stop_at,
                            input logic [7:0] last_keep, input int short_beat);
    int          nbeats;
    int          rem;
    logic [63:0] d;
    logic [7:0]  k;
    nbeats = (len + 7) / 8;
    for (int b = 0; b < nbeats; b++) begin
      if (stop_at >= 0 && b * 8 >= stop_at) return;
      for (int j = 0; j < 8; j++) begin
        d[j*8 +: 8] = gen_byte(b * 8 + j);
        if (b * 8 + j == corrupt_at) d[j*8 +: 8] = 8'hFF;
      end
      rem = len - b * 8;
      k = (rem >= 8) ? 8'hFF : (8'hFF >> (8 - rem));
      if (b == nbeats - 1 && last_keep != 8'h00) k = last_keep;
      if (b == short_beat) k = 8'h7F;
      send_beat(d, k, (b == nbeats - 1), src, clr_last && (b == nbeats - 1));
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    tdata  = '0;
    tkeep  = '0;
    tuser  = '0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    clear  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tready",   32'(tready),   32'd0);
    check("rst_pkt",      pkt_count,     32'd0);
    check("rst_err",      err_count,     32'd0);
    check("rst_last_len", 32'(last_len), 32'd0);
    check("rst_flags",    32'({data_err, len_err, src_err}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("tready_after_rst", 32'(tready), 32'd1);

    // Three good back-to-back frames
    repeat (3) send_frame(1500, -1, 8'h01, 1'b0, -1, 8'h00, -1);
    @(negedge clk);
    check("good3_pkt",   pkt_count,     32'd3);
    check("good3_err",   err_count,     32'd0);
    check("good3_len",   32'(last_len), 32'd1500);
    check("good3_flags", 32'({data_err, len_err, src_err}), 32'd0);

    // Last beat keep 0x3C: lanes 2..5 hold bytes 1498..1501, 4 bytes counted
    send_frame(1500, -1, 8'h01, 1'b0, -1, 8'h3C, -1);
    @(negedge clk);
    check("offkeep_pkt",   pkt_count,     32'd4);
    check("offkeep_err",   err_count,     32'd0);
    check("offkeep_len",   32'(last_len), 32'd1500);

    pulse_clear();
    check("clear_pkt", pkt_count,     32'd0);
    check("clear_len", 32'(last_len), 32'd0);

    // Good frame, then byte 100 corrupted
    send_frame(1500, -1,  8'h01, 1'b0, -1, 8'h00, -1);
    send_frame(1500, 100, 8'h01, 1'b0, -1, 8'h00, -1);
    @(negedge clk);
    check("corrupt_pkt",  pkt_count,     32'd2);
    check("corrupt_err",  err_count,     32'd1);
    check("corrupt_data", 32'(data_err), 32'd1);
    check("corrupt_lsrc", 32'({len_err, src_err}), 32'd0);

    // Short frame: 187 full beats
    pulse_clear();
    send_frame(1496, -1, 8'h01, 1'b0, -1, 8'h00, -1);
    @(negedge clk);
    check("short_len_err", 32'(len_err),  32'd1);
    check("short_last",    32'(last_len), 32'd1496);
    check("short_err",     err_count,     32'd1);
    check("short_data",    32'(data_err), 32'd0);

    // Wrong source port
    pulse_clear();
    send_frame(1500, -1, 8'h04, 1'b0, -1, 8'h00, -1);
    @(negedge clk);
    check("src_src_err", 32'(src_err), 32'd1);
    check("src_dl",      32'({data_err, len_err}), 32'd0);
    check("src_err_cnt", err_count, 32'd1);
    check("src_pkt",     pkt_count, 32'd1);

    // clear coincident with finalize discards that frame
    send_frame(1500, -1, 8'h01, 1'b1, -1, 8'h00, -1);
    @(negedge clk);
    check("clrfin_pkt",   pkt_count,     32'd0);
    check("clrfin_err",   err_count,     32'd0);
    check("clrfin_len",   32'(last_len), 32'd0);
    check("clrfin_flags", 32'({data_err, len_err, src_err}), 32'd0);
    send_frame(1500, -1, 8'h01, 1'b0, -1, 8'h00, -1);
    @(negedge clk);
    check("clrfin_next_pkt", pkt_count,     32'd1);
    check("clrfin_next_len", 32'(last_len), 32'd1500);

    // Partial keep on non-last beat 10: dropped, 1499 bytes total
    pulse_clear();
    send_frame(1500, -1, 8'h01, 1'b0, -1, 8'h00, 10);
    @(negedge clk);
    check("drop_len_err", 32'(len_err),  32'd1);
    check("drop_data",    32'(data_err), 32'd0);
    check("drop_err",     err_count,     32'd1);
    check("drop_last",    32'(last_len), 32'd1499);

    // Reset at offset 512, then a good frame
    send_frame(1500, -1, 8'h01, 1'b0, 512, 8'h00, -1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_pkt",    pkt_count,   32'd0);
    check("midrst_tready", 32'(tready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    send_frame(1500, -1, 8'h01, 1'b0, -1, 8'h00, -1);
    @(negedge clk);
    check("midrst_next_pkt",   pkt_count, 32'd1);
    check("midrst_next_err",   err_count, 32'd0);
    check("midrst_next_flags", 32'({data_err, len_err, src_err}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
